generador_obstaculos: RTL



---
 rtl/generador_obstaculos.sv | 127 ++++++++++++
 1 files changed

// File: rtl/generador_obstaculos.sv
// generador_obstaculos: obstacle sequencer for the HEROE game.
// Counts a programmable number of scroll ticks, then emits a pseudo-random
// obstacle type (0..9) for the pattern ROM. It also tracks the number of
// emissions and the difficulty level, and shortens the spacing as the level
// rises.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   tick       one-cycle scroll pulse
//   habilitar  game running; low freezes the block
//   reiniciar  synchronous restart to the reset values
//   tipo_obs   obstacle type, 4'hF = none
//   nuevo_obs  one-cycle pulse when a new tipo_obs becomes valid
//   nivel      difficulty level, saturates at 15
//   cuenta_obs total emissions, saturates at 255
module generador_obstaculos #(
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter int         TICKS_INI     = 8,
  parameter int         TICKS_MIN     = 3,
  parameter int         OBS_POR_NIVEL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       habilitar,
  input  logic       reiniciar,
  output logic [3:0] tipo_obs,
  output logic       nuevo_obs,
  output logic [3:0] nivel,
  output logic [7:0] cuenta_obs
);

  localparam logic [7:0] INI  = 8'(TICKS_INI);
  localparam logic [7:0] MINT = 8'(TICKS_MIN);
  localparam logic [7:0] PNIV = 8'(OBS_POR_NIVEL);

  typedef enum logic [1:0] {INACTIVO, ESPERA, EMITIR} estado_t;

  estado_t    state, state_next;
  logic [7:0] lfsr, intervalo, contador, obs_en_nivel;

  logic       tick_ok;
  logic       realimentacion;
  logic [3:0] n, t_base, t_sel;
  logic       fin_nivel;
  logic [7:0] intervalo_next;

  always_comb begin
    // Ticks only count while actively waiting; everything else drops them.
    tick_ok        = tick & habilitar & (state == ESPERA);
    realimentacion = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Fold 10..15 onto 4..9, then bump by one if it would repeat the last type.
    n      = lfsr[3:0];
    t_base = (n >= 4'd10) ? (n - 4'd6) : n;
    if (t_base == tipo_obs) t_sel = (t_base == 4'd9) ? 4'd0 : (t_base + 4'd1);
    else                    t_sel = t_base;

    // obs_en_nivel < PNIV always holds, so the +1 cannot wrap.
    fin_nivel = ((obs_en_nivel + 8'd1) == PNIV);
    if (fin_nivel) intervalo_next = (intervalo > MINT) ? (intervalo - 8'd1) : MINT;
    else           intervalo_next = intervalo;
  end

  always_comb begin
    state_next = state;
    case (state)
      INACTIVO: if (habilitar) state_next = ESPERA;
      ESPERA:   if (tick_ok && contador == 8'd1) state_next = EMITIR;
      EMITIR:   state_next = ESPERA;
      default:  state_next = INACTIVO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            state <= INACTIVO;
    else if (reiniciar) state <= INACTIVO;
    else                state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= LFSR_SEED;
      intervalo    <= INI;
      contador     <= 8'd0;
      obs_en_nivel <= 8'd0;
      tipo_obs     <= 4'hF;
      nuevo_obs    <= 1'b0;
      nivel        <= 4'd0;
      cuenta_obs   <= 8'd0;
    end else if (reiniciar) begin
      lfsr         <= LFSR_SEED;
      intervalo    <= INI;
      contador     <= 8'd0;
      obs_en_nivel <= 8'd0;
      tipo_obs     <= 4'hF;
      nuevo_obs    <= 1'b0;
      nivel        <= 4'd0;
      cuenta_obs   <= 8'd0;
    end else begin
      // Pulse only in the cycle after EMITIR, regardless of habilitar.
      nuevo_obs <= (state == EMITIR);
      case (state)
        INACTIVO: if (habilitar) contador <= intervalo;
        ESPERA: if (tick_ok) begin
          lfsr     <= {lfsr[6:0], realimentacion};
          contador <= contador - 8'd1;
        end
        EMITIR: begin
          tipo_obs   <= t_sel;
          cuenta_obs <= (cuenta_obs != 8'hFF) ? (cuenta_obs + 8'd1) : cuenta_obs;
          if (fin_nivel) begin
            obs_en_nivel <= 8'd0;
            nivel        <= (nivel != 4'hF) ? (nivel + 4'd1) : nivel;
          end else begin
            obs_en_nivel <= obs_en_nivel + 8'd1;
          end
          intervalo <= intervalo_next;
          contador  <= intervalo_next;
        end
        default: ;
      endcase
    end
  end

endmodule
